clk_div_bank: RTL and testbench

- Parametrised successor to the fixed 4f/2f/f PHY clock generator.
- Produces NUM_CH divided clocks from the fastest PHY clock (clk16f).
- Each channel has a runtime-programmable half-period, a per-channel enable, a glitch-free ratio change and a one-cycle rising-edge strobe that downstream logic uses as a clock-enable.
- A global resync re-aligns all channels; an aligned flag reports whether the channels are still phase-coherent.

---
 rtl/clk_div_bank_pkg.sv | 21 ++
 rtl/clk_div_bank_if.sv | 28 ++
 rtl/clk_div_chan.sv | 54 +++++
 rtl/clk_div_bank.sv | 56 +++++
 tb/tb_clk_div_bank.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/clk_div_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank_pkg
// Description : Shared PHY clocking constants for the divided-clock bank.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_bank_pkg;

    localparam int CLK_DIV_CNT_W_DEFAULT = 4;

    // Half-period-minus-one values that reproduce the legacy 4f/2f/f clocks
    localparam int HP_4F = 1;
    localparam int HP_2F = 3;
    localparam int HP_F  = 7;

    localparam int CH_4F = 0;
    localparam int CH_2F = 1;
    localparam int CH_F  = 2;

endpackage
`default_nettype wire

// File: rtl/clk_div_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank_if
// Description : Control and divided-clock bundle of the clock divider bank.
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_bank_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 4
);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*CNT_W-1:0] half_per;
    logic                    resync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       rise_tick;
    logic                    aligned;

    modport master (
        output enable, half_per, resync,
        input  clk_out, rise_tick, aligned
    );

    modport slave (
        input  enable, half_per, resync,
        output clk_out, rise_tick, aligned
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divided-clock channel with shadowed, glitch-free ratio.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan #(
    parameter int CNT_W = 4
) (
    input  logic             clk16f,
    input  logic             i_restart,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_half_per,
    output logic             o_clk_out,
    output logic             o_rise_tick,
    output logic             o_ratio_chg
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_h;
    logic             r_clk_out;
    logic             r_rise_tick;
    logic             w_terminal;
    logic             w_rise;

    // ">=" recovers from a count left above a freshly shrunk ratio
    assign w_terminal  = (r_cnt >= r_act_h);
    assign w_rise      = i_enable & w_terminal & ~r_clk_out;
    // Flags a shadow-ratio load that changes the value, outside a restart
    assign o_ratio_chg = ~i_restart & (~i_enable | w_rise) & (i_half_per != r_act_h);

    always_ff @(posedge clk16f) begin
        if (i_restart || !i_enable) begin
            r_cnt       <= '0;
            r_clk_out   <= 1'b1;
            r_rise_tick <= 1'b0;
            r_act_h     <= i_half_per;
        end else begin
            r_rise_tick <= w_rise;
            if (w_terminal) begin
                r_clk_out <= ~r_clk_out;
                r_cnt     <= '0;
                if (w_rise) begin
                    r_act_h <= i_half_per;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_clk_out   = r_clk_out;
    assign o_rise_tick = r_rise_tick;
endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Bank of NUM_CH programmable clock dividers with phase tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clk_div_bank_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = CLK_DIV_CNT_W_DEFAULT
) (
    input  logic           clk16f,
    input  logic           reset,
    clk_div_bank_if.slave  bus
);
    logic              w_restart;
    logic [NUM_CH-1:0] w_ratio_chg;
    logic [NUM_CH-1:0] w_clk_out;
    logic [NUM_CH-1:0] w_rise_tick;
    logic [NUM_CH-1:0] r_en_q;
    logic              r_aligned;

    assign w_restart = reset | bus.resync;

    generate
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
            clk_div_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .clk16f      (clk16f),
                .i_restart   (w_restart),
                .i_enable    (bus.enable[ch]),
                .i_half_per  (bus.half_per[ch*CNT_W +: CNT_W]),
                .o_clk_out   (w_clk_out[ch]),
                .o_rise_tick (w_rise_tick[ch]),
                .o_ratio_chg (w_ratio_chg[ch])
            );
        end
    endgenerate

    // Coherence is lost for good once any ratio or enable moves on its own
    always_ff @(posedge clk16f) begin
        r_en_q <= bus.enable;
        if (w_restart) begin
            r_aligned <= 1'b1;
        end else if ((|w_ratio_chg) || (bus.enable != r_en_q)) begin
            r_aligned <= 1'b0;
        end
    end

    assign bus.clk_out   = w_clk_out;
    assign bus.rise_tick = w_rise_tick;
    assign bus.aligned   = r_aligned;
endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Directed self-checking bench with a phase-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 4;

    logic clk16f;
    logic reset;
    int   n_checks;
    int   n_err;
    int   edge_no;
    bit   chk_en;

    // Model: edges elapsed since the current high phase began, and its ratio
    int   m_k [NUM_CH];
    int   m_h [NUM_CH];
    bit   m_tick [NUM_CH];
    bit   m_aligned;
    bit   m_chg;
    logic [NUM_CH-1:0] m_en_prev;

    clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_div_bank #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk16f (clk16f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk16f = 1'b0;
    always #5 clk16f = ~clk16f;

    function automatic int hp(input int ch);
        return int'(bus.half_per[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_no, act, exp);
        end
    endtask

    always @(posedge clk16f) begin
        edge_no++;
        if (reset || bus.resync) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_k[ch] = 0; m_h[ch] = hp(ch); m_tick[ch] = 0;
            end
            m_aligned = 1;
        end else begin
            m_chg = (bus.enable != m_en_prev);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_tick[ch] = 0;
                if (!bus.enable[ch]) begin
                    if (hp(ch) != m_h[ch]) m_chg = 1;
                    m_k[ch] = 0; m_h[ch] = hp(ch);
                end else begin
                    m_k[ch]++;
                    if (m_k[ch] == 2*(m_h[ch]+1)) begin
                        if (hp(ch) != m_h[ch]) m_chg = 1;
                        m_k[ch] = 0; m_h[ch] = hp(ch); m_tick[ch] = 1;
                    end
                end
            end
            if (m_chg) m_aligned = 0;
        end
        m_en_prev = bus.enable;
    end

    always @(negedge clk16f) begin
        logic [NUM_CH-1:0] e_clk, e_tick;
        if (chk_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                e_clk[ch]  = (m_k[ch] < m_h[ch] + 1);
                e_tick[ch] = m_tick[ch];
            end
            chk("model clk_out", 32'(bus.clk_out), 32'(e_clk));
            chk("model rise_tick", 32'(bus.rise_tick), 32'(e_tick));
            chk("model aligned", 32'(bus.aligned), 32'(m_aligned));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk16f);
        @(negedge clk16f);
    endtask

    task automatic check_default_pattern();
        step(2);  chk("fall ch0", 32'(bus.clk_out), 32'h6);
        step(2);  chk("edge4 clk", 32'(bus.clk_out), 32'h5);
                  chk("edge4 tick", 32'(bus.rise_tick), 32'h1);
        step(4);  chk("edge8 clk", 32'(bus.clk_out), 32'h3);
                  chk("edge8 tick", 32'(bus.rise_tick), 32'h3);
        step(8);  chk("edge16 clk", 32'(bus.clk_out), 32'h7);
                  chk("edge16 tick", 32'(bus.rise_tick), 32'h7);
                  chk("edge16 aligned", 32'(bus.aligned), 32'h1);
    endtask

    initial begin
        n_checks = 0; n_err = 0; edge_no = 0; chk_en = 0;
        m_en_prev = '0;
        reset = 1'b1;
        bus.resync   = 1'b0;
        bus.enable   = 3'b111;
        bus.half_per = {4'd7, 4'd3, 4'd1};
        repeat (2) @(posedge clk16f);
        @(negedge clk16f);
        chk("reset clk_out", 32'(bus.clk_out), 32'h7);
        chk("reset tick", 32'(bus.rise_tick), 32'h0);
        chk("reset aligned", 32'(bus.aligned), 32'h1);
        reset = 1'b0; edge_no = 0; chk_en = 1;

        check_default_pattern();

        // Enable drop on ch1 during its low phase (falls at edge 20)
        step(4);  chk("ch1 low", 32'(bus.clk_out[1]), 32'h0);
                  chk("pre-drop aligned", 32'(bus.aligned), 32'h1);
        bus.enable = 3'b101;
        step(1);  chk("ch1 parked", 32'(bus.clk_out[1]), 32'h1);
                  chk("ch1 no tick", 32'(bus.rise_tick[1]), 32'h0);
                  chk("drop aligned", 32'(bus.aligned), 32'h0);
        step(2);  bus.enable = 3'b111;
        step(3);  chk("ch1 still high", 32'(bus.clk_out[1]), 32'h1);
        step(1);  chk("ch1 falls", 32'(bus.clk_out[1]), 32'h0);

        // Resync restores phase coherence and the default pattern
        bus.resync = 1'b1;
        step(1);  chk("resync clk", 32'(bus.clk_out), 32'h7);
                  chk("resync tick", 32'(bus.rise_tick), 32'h0);
                  chk("resync aligned", 32'(bus.aligned), 32'h1);
        bus.resync = 1'b0; edge_no = 0;
        check_default_pattern();

        // ch0 ratio 1->3 requested during its low phase
        step(2);  chk("ch0 low", 32'(bus.clk_out[0]), 32'h0);
        bus.half_per = {4'd7, 4'd3, 4'd3};
        step(1);  chk("ch0 old low", 32'(bus.clk_out[0]), 32'h0);
        step(1);  chk("ch0 rise", 32'(bus.clk_out[0]), 32'h1);
                  chk("ch0 tick", 32'(bus.rise_tick[0]), 32'h1);
                  chk("ratio aligned", 32'(bus.aligned), 32'h0);
        step(3);  chk("ch0 high4", 32'(bus.clk_out[0]), 32'h1);
        step(1);  chk("ch0 fall4", 32'(bus.clk_out[0]), 32'h0);
        step(3);  chk("ch0 low4", 32'(bus.clk_out[0]), 32'h0);
        step(1);  chk("ch0 rise4", 32'(bus.clk_out[0]), 32'h1);

        // Boundary ratios on ch2: 0 then 15
        bus.half_per = {4'd0, 4'd3, 4'd3};
        step(4);  chk("ch2 h0 load", 32'(bus.rise_tick[2]), 32'h1);
        step(1);  chk("ch2 h0 low", 32'({bus.clk_out[2], bus.rise_tick[2]}), 32'h0);
        step(1);  chk("ch2 h0 high", 32'({bus.clk_out[2], bus.rise_tick[2]}), 32'h3);
        step(6);  chk("ch2 h0 phase", 32'(bus.clk_out[2]), 32'h1);
        bus.half_per = {4'd15, 4'd3, 4'd3};
        step(2);  chk("ch2 h15 load", 32'(bus.rise_tick[2]), 32'h1);
        step(15); chk("ch2 h15 high", 32'(bus.clk_out[2]), 32'h1);
        step(1);  chk("ch2 h15 fall", 32'(bus.clk_out[2]), 32'h0);
        step(16); chk("ch2 h15 rise", 32'({bus.clk_out[2], bus.rise_tick[2]}), 32'h3);

        // Reset and resync together behave as reset
        step(5);
        bus.half_per = {4'd7, 4'd3, 4'd1};
        reset = 1'b1; bus.resync = 1'b1;
        step(1);  chk("both clk", 32'(bus.clk_out), 32'h7);
                  chk("both tick", 32'(bus.rise_tick), 32'h0);
                  chk("both aligned", 32'(bus.aligned), 32'h1);
        reset = 1'b0; bus.resync = 1'b0; edge_no = 0;
        check_default_pattern();

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
